gate_sensor_conditioner: RTL

- Upstream front end of the parking gate controller.
- Synchronizes and debounces the raw front and back presence sensors, and drives the clean front_sensor/back_sensor levels that the gate controller consumes.
- Tracks each car's passage through the sensor pair with a small FSM and emits single-cycle event pulses: arrival, completed passage, abort, wrong-way.
- The occupancy and display logic uses these pulses.

---
 rtl/gate_pkg.sv | 15 +
 rtl/gate_sensor_conditioner_if.sv | 35 +++
 rtl/sensor_debounce.sv | 52 +++++
 rtl/gate_sensor_conditioner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and defaults for the parking gate sensor front end.
package gate_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF           = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFront = 3'd1,
    StBoth  = 3'd2,
    StBack  = 3'd3,
    StWrong = 3'd4
  } gate_state_e;

endpackage

// File: rtl/gate_sensor_conditioner_if.sv
// Sensor inputs and conditioned outputs of the gate sensor front end.
interface gate_sensor_conditioner_if;

  logic front_raw;
  logic back_raw;
  logic front_sensor;
  logic back_sensor;
  logic car_arrived;
  logic car_passed;
  logic car_aborted;
  logic wrong_way;

  modport master (
    output front_raw,
    output back_raw,
    input  front_sensor,
    input  back_sensor,
    input  car_arrived,
    input  car_passed,
    input  car_aborted,
    input  wrong_way
  );

  modport slave (
    input  front_raw,
    input  back_raw,
    output front_sensor,
    output back_sensor,
    output car_arrived,
    output car_passed,
    output car_aborted,
    output wrong_way
  );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw sensor.
module sensor_debounce
  import gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_raw,
  output logic o_clean
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_clean_d;

  // Any sample matching the clean level restarts the stability count.
  always_comb begin
    w_cnt_d   = '0;
    w_clean_d = r_clean;
    if (r_s2 != r_clean) begin
      if (r_cnt == CntMax) begin
        w_clean_d = r_s2;
      end else begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_cnt   <= w_cnt_d;
      r_clean <= w_clean_d;
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/gate_sensor_conditioner.sv
// Debounces the front/back presence sensors and tracks each car's passage,
// emitting registered single-cycle arrival/passed/aborted/wrong-way pulses.
module gate_sensor_conditioner
  import gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  gate_sensor_conditioner_if.slave   bus
);

  logic        w_front;
  logic        w_back;
  gate_state_e r_state;
  gate_state_e w_state_d;
  logic        r_car_arrived;
  logic        r_car_passed;
  logic        r_car_aborted;
  logic        r_wrong_way;
  logic        w_arrived_d;
  logic        w_passed_d;
  logic        w_aborted_d;
  logic        w_wrong_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_front_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .i_raw   (bus.front_raw),
    .o_clean (w_front)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_back_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .i_raw   (bus.back_raw),
    .o_clean (w_back)
  );

  always_comb begin
    w_state_d   = r_state;
    w_arrived_d = 1'b0;
    w_passed_d  = 1'b0;
    w_aborted_d = 1'b0;
    w_wrong_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_front && !w_back) begin
          w_state_d   = StFront;
          w_arrived_d = 1'b1;
        end else if (w_front && w_back) begin
          w_state_d   = StBoth;
          w_arrived_d = 1'b1;
        end else if (!w_front && w_back) begin
          w_state_d = StWrong;
          w_wrong_d = 1'b1;
        end
      end
      StFront: begin
        if (w_back) begin
          w_state_d = StBoth;
        end else if (!w_front) begin
          w_state_d   = StIdle;
          w_aborted_d = 1'b1;
        end
      end
      StBoth: begin
        if (!w_front && w_back) begin
          w_state_d = StBack;
        end else if (w_front && !w_back) begin
          w_state_d = StFront;
        end else if (!w_front && !w_back) begin
          w_state_d  = StIdle;
          w_passed_d = 1'b1;
        end
      end
      StBack: begin
        if (w_front) begin
          w_state_d = StBoth;
        end else if (!w_back) begin
          w_state_d  = StIdle;
          w_passed_d = 1'b1;
        end
      end
      StWrong: begin
        // Swallow the whole wrong-way episode; only an empty pair re-arms.
        if (!w_front && !w_back) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= StIdle;
      r_car_arrived <= 1'b0;
      r_car_passed  <= 1'b0;
      r_car_aborted <= 1'b0;
      r_wrong_way   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_car_arrived <= w_arrived_d;
      r_car_passed  <= w_passed_d;
      r_car_aborted <= w_aborted_d;
      r_wrong_way   <= w_wrong_d;
    end
  end

  assign bus.front_sensor = w_front;
  assign bus.back_sensor  = w_back;
  assign bus.car_arrived  = r_car_arrived;
  assign bus.car_passed   = r_car_passed;
  assign bus.car_aborted  = r_car_aborted;
  assign bus.wrong_way    = r_wrong_way;

endmodule
